// File: rtl/vm_pkg.sv
// Shared types, default prices and credit arithmetic for the vending controller.
package vm_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } vm_state_e;

  // Default slot prices packed slot 0 in the low bits: water 20, 25, 30, coffee 80.
  localparam int unsigned DEFAULT_MONEY_W = 12;
  localparam logic [4*DEFAULT_MONEY_W-1:0] DEFAULT_PRICES =
    {12'd80, 12'd30, 12'd25, 12'd20};

  // Add two non-negative amounts with one bit of headroom, then clamp at lim.
  // Callers pass zero-extended money values, so the carry bit is never lost.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/vm_slot.sv
// One drink slot: stock counter plus registered available/sold_out flags.
module vm_slot
  import vm_pkg::*;
#(
  parameter int unsigned MONEY_W    = 12,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 3,
  parameter logic [MONEY_W-1:0] PRICE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restock,
  input  logic               take,
  input  logic [MONEY_W-1:0] credit,
  output logic               can_take,
  output logic               available,
  output logic               sold_out
);

  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               available_q, available_d;
  logic               sold_out_q, sold_out_d;

  // Live purchase qualifier used by the FSM; it sees this cycle's credit and stock.
  assign can_take = (credit >= PRICE) && (stock_q != '0);

  // Next stock and next display flags; the flags trail credit/stock by one cycle.
  always_comb begin
    stock_d     = stock_q;
    available_d = can_take;
    sold_out_d  = (stock_q == '0);
    if (restock) begin
      stock_d = STOCK_INIT;
    end else if (take && (stock_q != '0)) begin
      stock_d = stock_q - 1'b1;
    end
  end

  // Stock and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_q     <= STOCK_INIT;
      available_q <= 1'b0;
      sold_out_q  <= 1'b0;
    end else begin
      stock_q     <= stock_d;
      available_q <= available_d;
      sold_out_q  <= sold_out_d;
    end
  end

  assign available = available_q;
  assign sold_out  = sold_out_q;

endmodule

// File: rtl/vending_machine_ctrl.sv
// Vending controller: credit accumulation, lowest-index vend, paced coin refund.
module vending_machine_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned N_DRINK     = 4,
  parameter int unsigned MONEY_W     = 12,
  parameter logic [N_DRINK*MONEY_W-1:0] PRICES = DEFAULT_PRICES,
  parameter int unsigned MAX_CREDIT  = 100,
  parameter int unsigned REFUND_STEP = 5,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       coin_valid,
  input  logic [MONEY_W-1:0]         coin_value,
  input  logic                       cancel,
  input  logic [N_DRINK-1:0]         select,
  input  logic                       restock,
  output logic [MONEY_W-1:0]         credit,
  output logic [N_DRINK-1:0]         available,
  output logic [N_DRINK-1:0]         sold_out,
  output logic                       dispense_valid,
  output logic [$clog2(N_DRINK)-1:0] dispense_id,
  output logic                       refund_pulse,
  output logic                       coin_reject,
  output logic                       busy
);

  localparam int unsigned ID_W = $clog2(N_DRINK);
  localparam logic [MONEY_W-1:0] STEP = MONEY_W'(REFUND_STEP);

  vm_state_e          state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic               dispense_valid_q, dispense_valid_d;
  logic [ID_W-1:0]    dispense_id_q, dispense_id_d;
  logic               refund_pulse_q, refund_pulse_d;
  logic               coin_reject_q, coin_reject_d;

  logic [N_DRINK-1:0] can_take;
  logic [N_DRINK-1:0] take_vec;
  logic               restock_go;

  logic               sel_hit;
  logic [ID_W-1:0]    sel_idx;
  logic [MONEY_W-1:0] sel_price;
  logic [N_DRINK-1:0] sel_onehot;

  logic [MONEY_W-1:0] coin_credit;
  logic [MONEY_W-1:0] first_coin_credit;
  logic [MONEY_W-1:0] refund_amt;
  logic [MONEY_W-1:0] credit_after_refund;

  // Per-slot stock and flags.
  for (genvar gi = 0; gi < N_DRINK; gi++) begin : g_slot
    vm_slot #(
      .MONEY_W   (MONEY_W),
      .STOCK_W   (STOCK_W),
      .INIT_STOCK(INIT_STOCK),
      .PRICE     (PRICES[gi*MONEY_W +: MONEY_W])
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .restock  (restock_go),
      .take     (take_vec[gi]),
      .credit   (credit_q),
      .can_take (can_take[gi]),
      .available(available[gi]),
      .sold_out (sold_out[gi])
    );
  end

  // Pick the lowest-index requested slot that is affordable and in stock right now.
  always_comb begin
    sel_hit    = 1'b0;
    sel_idx    = '0;
    sel_price  = '0;
    sel_onehot = '0;
    for (int i = N_DRINK - 1; i >= 0; i--) begin
      if (select[i] && can_take[i]) begin
        sel_hit       = 1'b1;
        sel_idx       = ID_W'(i);
        sel_price     = PRICES[i*MONEY_W +: MONEY_W];
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Credit arithmetic shared by the FSM: saturating coin add and clamped refund step.
  always_comb begin
    coin_credit         = MONEY_W'(sat_add(32'(credit_q), 32'(coin_value), 32'(MAX_CREDIT)));
    first_coin_credit   = MONEY_W'(sat_add(32'd0, 32'(coin_value), 32'(MAX_CREDIT)));
    refund_amt          = (credit_q < STEP) ? credit_q : STEP;
    credit_after_refund = credit_q - refund_amt;
  end

  // Next-state and registered-output logic; cancel beats select beats coin in CREDIT.
  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_valid_d = 1'b0;
    dispense_id_d    = dispense_id_q;
    refund_pulse_d   = 1'b0;
    coin_reject_d    = 1'b0;
    take_vec         = '0;
    restock_go       = 1'b0;

    unique case (state_q)
      IDLE: begin
        restock_go = restock;
        if (coin_valid) begin
          credit_d = first_coin_credit;
          state_d  = CREDIT;
        end
      end

      CREDIT: begin
        if (cancel) begin
          state_d       = REFUND;
          coin_reject_d = coin_valid;
        end else if (sel_hit) begin
          credit_d         = credit_q - sel_price;
          take_vec         = sel_onehot;
          dispense_valid_d = 1'b1;
          dispense_id_d    = sel_idx;
          state_d          = DISPENSE;
          coin_reject_d    = coin_valid;
        end else if (coin_valid) begin
          credit_d = coin_credit;
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_valid;
        state_d       = (credit_q != '0) ? REFUND : IDLE;
      end

      REFUND: begin
        coin_reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          credit_d       = credit_after_refund;
          refund_pulse_d = 1'b1;
          if (credit_after_refund == '0) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset discards any credit in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      refund_pulse_q   <= 1'b0;
      coin_reject_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      refund_pulse_q   <= refund_pulse_d;
      coin_reject_q    <= coin_reject_d;
    end
  end

  assign credit         = credit_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_id    = dispense_id_q;
  assign refund_pulse   = refund_pulse_q;
  assign coin_reject    = coin_reject_q;
  assign busy           = (state_q == REFUND) || (state_q == DISPENSE);

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Directed bench for vending_machine_ctrl with hand-computed expectations.
module tb_vending_machine_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        coin_valid = 1'b0;
  logic [11:0] coin_value = '0;
  logic        cancel = 1'b0;
  logic [3:0]  select = '0;
  logic        restock = 1'b0;
  logic [11:0] credit;
  logic [3:0]  available;
  logic [3:0]  sold_out;
  logic        dispense_valid;
  logic [1:0]  dispense_id;
  logic        refund_pulse;
  logic        coin_reject;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vending_machine_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .cancel        (cancel),
    .select        (select),
    .restock       (restock),
    .credit        (credit),
    .available     (available),
    .sold_out      (sold_out),
    .dispense_valid(dispense_valid),
    .dispense_id   (dispense_id),
    .refund_pulse  (refund_pulse),
    .coin_reject   (coin_reject),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input int v);
    coin_valid = 1'b1;
    coin_value = 12'(v);
    cyc();
    coin_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] s);
    select = s;
    cyc();
    select = '0;
  endtask

  initial begin
    // Reset values
    repeat (2) cyc();
    check("rst_credit", 32'(credit), 0);
    check("rst_avail", 32'(available), 0);
    check("rst_soldout", 32'(sold_out), 0);
    check("rst_outs", 32'({dispense_valid, dispense_id, refund_pulse, coin_reject, busy}), 0);
    rst = 1'b0;
    cyc();

    // Coins 50,10,10 and lagging available
    put_coin(50);
    check("c50_credit", 32'(credit), 50);
    check("c50_avail_lag", 32'(available), 0);
    cyc();
    check("c50_avail", 32'(available), 32'h7);
    put_coin(10);
    put_coin(10);
    check("c70_credit", 32'(credit), 70);
    cyc();
    check("c70_avail", 32'(available), 32'h7);

    // Unaffordable coffee ignored, then slot 1 wins over slot 2
    press(4'b1000);
    check("coffee_credit", 32'(credit), 70);
    check("coffee_nodisp", 32'(dispense_valid), 0);
    check("coffee_busy", 32'(busy), 0);
    press(4'b0110);
    check("vend1_valid", 32'(dispense_valid), 1);
    check("vend1_id", 32'(dispense_id), 1);
    check("vend1_credit", 32'(credit), 45);
    check("vend1_busy", 32'(busy), 1);
    cyc();
    check("vend1_pulse_once", 32'(dispense_valid), 0);
    check("vend1_id_hold", 32'(dispense_id), 1);
    check("refund_busy", 32'(busy), 1);

    // Paced refund of 45, with a rejected coin in between
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        if (i == 0 && j == 0) begin
          coin_valid = 1'b1;
          coin_value = 12'd10;
        end
        cyc();
        coin_valid = 1'b0;
        if (i == 0 && j == 0) begin
          check("refund_coin_reject", 32'(coin_reject), 1);
          check("refund_coin_credit", 32'(credit), 45);
        end
        if (j == 1) check("refund_idle_pulse", 32'(refund_pulse), 0);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      check("refund_pulse", 32'(refund_pulse), 1);
      check("refund_credit", 32'(credit), 32'(45 - 5 * (i + 1)));
    end
    check("refund_done_idle", 32'(busy), 0);
    cyc();
    check("refund_pulse_clear", 32'(refund_pulse), 0);

    // Saturation and cancel+coin collision
    put_coin(50);
    put_coin(40);
    check("sat_90", 32'(credit), 90);
    put_coin(50);
    check("sat_100", 32'(credit), 100);
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin_value = 12'd10;
    cyc();
    cancel = 1'b0;
    coin_valid = 1'b0;
    check("cancel_busy", 32'(busy), 1);
    check("cancel_reject", 32'(coin_reject), 1);
    check("cancel_credit", 32'(credit), 100);
    tick = 1'b1;
    repeat (20) cyc();
    tick = 1'b0;
    check("sat_refund_credit", 32'(credit), 0);
    check("sat_refund_idle", 32'(busy), 0);

    // Water stock exhaustion
    for (int n = 0; n < 3; n++) begin
      put_coin(20);
      press(4'b0001);
      check("water_valid", 32'(dispense_valid), 1);
      check("water_id", 32'(dispense_id), 0);
      check("water_credit", 32'(credit), 0);
      cyc();
      check("water_idle", 32'(busy), 0);
    end
    check("water_soldout", 32'(sold_out), 32'h1);
    put_coin(20);
    press(4'b0001);
    check("water4_ignored", 32'(dispense_valid), 0);
    check("water4_credit", 32'(credit), 20);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    tick = 1'b1;
    repeat (4) cyc();
    tick = 1'b0;
    check("water4_refunded", 32'({busy, credit}), 0);
    restock = 1'b1;
    cyc();
    restock = 1'b0;
    cyc();
    check("restock_soldout", 32'(sold_out), 0);
    put_coin(20);
    press(4'b0001);
    check("restock_vend", 32'({dispense_valid, dispense_id}), 32'h4);
    cyc();

    // Slot 2 purchase, then asynchronous reset mid-refund at credit 30
    put_coin(20);
    put_coin(10);
    press(4'b0100);
    check("slot2_id", 32'(dispense_id), 2);
    cyc();
    put_coin(20);
    put_coin(10);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_credit", 32'(credit), 30);
    rst = 1'b1;
    #1;
    check("async_rst_credit", 32'(credit), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_avail", 32'(available), 0);
    check("async_rst_id", 32'(dispense_id), 0);
    check("async_rst_pulses", 32'({dispense_valid, refund_pulse, coin_reject, sold_out}), 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_credit", 32'(credit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
